// File: rtl/sweep_seq_ctrl_pkg.sv
// Shared types and config resolution for the sweep sequencer.
// Contents: FSM state enum, sweep mode enum, resolved-config struct and
// resolve_cfg(), which maps raw cfg_* inputs to start/stop/step plus an
// illegal flag. Values are carried at SWEEP_MAX_W bits so one function
// serves any instance width up to that limit.
package sweep_seq_ctrl_pkg;

  localparam int SWEEP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } sweep_state_t;

  typedef enum logic {
    FULL_RANGE   = 1'b0,
    CUSTOM_RANGE = 1'b1
  } sweep_mode_t;

  typedef struct packed {
    logic [SWEEP_MAX_W-1:0] start;
    logic [SWEEP_MAX_W-1:0] stop;
    logic [SWEEP_MAX_W-1:0] step;
    logic                   illegal;
  } sweep_cfg_t;

  // max_w is the instance value width; full-range N must lie in 1..max_w.
  function automatic sweep_cfg_t resolve_cfg(
    input sweep_mode_t            mode,
    input int unsigned            width,
    input int unsigned            max_w,
    input logic [SWEEP_MAX_W-1:0] start,
    input logic [SWEEP_MAX_W-1:0] stop,
    input logic [SWEEP_MAX_W-1:0] step
  );
    sweep_cfg_t r;
    r.start   = start;
    r.stop    = stop;
    r.step    = step;
    r.illegal = 1'b0;
    if (mode == FULL_RANGE) begin
      r.start   = '0;
      r.step    = 64'd1;
      r.illegal = (width == 0) || (width > max_w);
      // All-ones shifted down gives 2^N-1 without overflowing at N=64.
      r.stop    = r.illegal ? '0 : ({SWEEP_MAX_W{1'b1}} >> (SWEEP_MAX_W - width));
    end else begin
      r.illegal = (step == '0) || (start > stop);
    end
    return r;
  endfunction

endpackage

// File: rtl/sweep_seq_ctrl_delay_cnt.sv
// Loadable down-counter timing the idle gap between sweep values.
// Ports: clk, rst (async, active-high); load/load_val restart the count;
// expire is high while the count equals 1, i.e. the last idle cycle.
// The count parks at 0 when not reloaded.
module sweep_delay_cnt #(
  parameter int DLY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  output logic             expire
);

  logic [DLY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DLY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == DLY_W'(1));

endmodule

// File: rtl/sweep_seq_ctrl.sv
// Sweep sequencer: emits start..stop by step (or 0..2^N-1) on a
// valid/ready stream with a programmable idle gap after each accepted value.
// Ports: clk, rst (async, active-high); start/abort control; cfg_* sweep
// configuration sampled on an accepted start; out_val/out_valid/out_ready
// stream; busy, done (1-cycle), err (1-cycle), iter_cnt (accepted values).
//
// state | meaning
// ------+------------------------------------------------------
// IDLE  | waiting for start; cfg_* resolved and checked here
// DRIVE | out_valid high, value held until out_ready
// WAIT  | idle gap of cfg_delay cycles before the next value
// FIN   | done pulse, back to IDLE next cycle
module sweep_seq_ctrl
  import sweep_seq_ctrl_pkg::*;
#(
  parameter int W     = 32,
  parameter int DLY_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   cfg_mode,
  input  logic [$clog2(W+1)-1:0] cfg_width,
  input  logic [W-1:0]           cfg_start,
  input  logic [W-1:0]           cfg_stop,
  input  logic [W-1:0]           cfg_step,
  input  logic [DLY_W-1:0]       cfg_delay,
  output logic [W-1:0]           out_val,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [W:0]             iter_cnt
);

  sweep_state_t     state_q, state_d;
  logic [W-1:0]     cur_q, cur_d;
  logic [W-1:0]     stop_q, stop_d;
  logic [W-1:0]     step_q, step_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic [W:0]       iter_q, iter_d;
  logic             err_q, err_d;

  sweep_cfg_t rc;
  logic [W:0] nxt;
  logic       last;
  logic       hs;
  logic       cnt_load;
  logic       cnt_expire;

  assign rc = resolve_cfg(sweep_mode_t'(cfg_mode), 32'(cfg_width), W,
                          SWEEP_MAX_W'(cfg_start), SWEEP_MAX_W'(cfg_stop),
                          SWEEP_MAX_W'(cfg_step));

  if (W < SWEEP_MAX_W) begin : g_unused
    logic unused_rc_hi;
    assign unused_rc_hi = ^{rc.start[SWEEP_MAX_W-1:W], rc.stop[SWEEP_MAX_W-1:W],
                            rc.step[SWEEP_MAX_W-1:W]};
  end

  assign hs  = (state_q == DRIVE) && out_ready;
  // One extra bit so a step past 2^W-1 shows up as nxt > stop.
  assign nxt  = {1'b0, cur_q} + {1'b0, step_q};
  assign last = (cur_q == stop_q) || (nxt > {1'b0, stop_q});

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stop_d   = stop_q;
    step_d   = step_q;
    delay_d  = delay_q;
    iter_d   = iter_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;

    if (abort) begin
      // Abort in IDLE is a no-op, and also swallows a simultaneous start.
      state_d = IDLE;
      if (hs) iter_d = iter_q + (W+1)'(1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (rc.illegal) begin
              err_d = 1'b1;
            end else begin
              cur_d   = rc.start[W-1:0];
              stop_d  = rc.stop[W-1:0];
              step_d  = rc.step[W-1:0];
              delay_d = cfg_delay;
              iter_d  = '0;
              state_d = DRIVE;
            end
          end
        end
        DRIVE: begin
          if (hs) begin
            iter_d = iter_q + (W+1)'(1);
            if (last) begin
              state_d = FIN;
            end else begin
              cur_d = nxt[W-1:0];
              if (delay_q != '0) begin
                cnt_load = 1'b1;
                state_d  = WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_expire) state_d = DRIVE;
        end
        FIN: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      delay_q <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      delay_q <= delay_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  sweep_delay_cnt #(.DLY_W(DLY_W)) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (delay_q),
    .expire   (cnt_expire)
  );

  assign out_val   = cur_q;
  assign out_valid = (state_q == DRIVE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign iter_cnt  = iter_q;

endmodule

// File: tb/tb_sweep_seq_ctrl.sv
// Self-checking bench for sweep_seq_ctrl (W=8). Expected sequences come from
// a list model built with plain integer arithmetic; stream timing, gaps,
// done/err pulses and iter_cnt are checked at each falling edge.
module tb_sweep_seq_ctrl;

  localparam int W     = 8;
  localparam int DLY_W = 8;
  localparam int CW    = $clog2(W+1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cfg_mode = 1'b0;
  logic [CW-1:0]    cfg_width = '0;
  logic [W-1:0]     cfg_start = '0;
  logic [W-1:0]     cfg_stop = '0;
  logic [W-1:0]     cfg_step = '0;
  logic [DLY_W-1:0] cfg_delay = '0;
  logic [W-1:0]     out_val;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic [W:0]       iter_cnt;

  int n_chk = 0;
  int n_err = 0;
  int last_iter = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sweep_seq_ctrl #(.W(W), .DLY_W(DLY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cfg_mode  (cfg_mode),
    .cfg_width (cfg_width),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_step  (cfg_step),
    .cfg_delay (cfg_delay),
    .out_val   (out_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .iter_cnt  (iter_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: list of values a sweep must emit; returns 1 for an illegal config.
  function automatic bit build_exp(input bit mode, input int width, input int s0,
                                   input int s1, input int st);
    int lo, hi, stp, v;
    exp_q.delete();
    if (!mode) begin
      if (width < 1 || width > W) return 1'b1;
      lo = 0; hi = (1 << width) - 1; stp = 1;
    end else begin
      if (st == 0 || s0 > s1) return 1'b1;
      lo = s0; hi = s1; stp = st;
    end
    v = lo;
    do begin
      exp_q.push_back(v);
      v += stp;
    end while (v <= hi);
    return 1'b0;
  endfunction

  task automatic scramble_cfg();
    cfg_mode  = 1'($urandom);
    cfg_width = CW'($urandom_range(0, 9));
    cfg_start = W'($urandom);
    cfg_stop  = W'($urandom);
    cfg_step  = W'($urandom);
    cfg_delay = DLY_W'($urandom_range(0, 5));
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge idle.
  task automatic run_sweep(input bit mode, input int width, input int s0, input int s1,
                           input int st, input int dly, input bit rnd_rdy,
                           input int stall_val, input int stall_len,
                           input int abort_idx, input bit poke);
    bit illegal, gap_on, fin_next, end_next, ok_end;
    int idx, gap, stalls, len, budget;
    illegal = build_exp(mode, width, s0, s1, st);
    len = exp_q.size();
    idx = 0; gap = 0; stalls = 0;
    gap_on = 0; fin_next = 0; end_next = 0; ok_end = 0;
    budget = (len + 1) * (dly + 1) * 8 + stall_len + 40;

    cfg_mode  = mode;
    cfg_width = CW'(width);
    cfg_start = W'(s0);
    cfg_stop  = W'(s1);
    cfg_step  = W'(st);
    cfg_delay = DLY_W'(dly);
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();

    if (illegal) begin
      chk("err_pulse", err, 1);
      chk("err_busy", busy, 0);
      chk("err_valid", out_valid, 0);
      chk("err_iter", iter_cnt, last_iter);
      @(negedge clk);
      chk("err_clear", err, 0);
      chk("err_busy2", busy, 0);
      chk("err_valid2", out_valid, 0);
      return;
    end

    for (int cyc = 0; cyc < budget && !ok_end; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      if (fin_next) begin
        chk("done_pulse", done, 1);
        chk("fin_valid", out_valid, 0);
        chk("fin_busy", busy, 1);
        chk("fin_iter", iter_cnt, len);
        fin_next = 0;
        end_next = 1;
      end else if (end_next) begin
        chk("done_once", done, 0);
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
        chk("end_iter", iter_cnt, len);
        last_iter = len;
        ok_end = 1;
      end else begin
        chk("run_done", done, 0);
        chk("run_busy", busy, 1);
        chk("run_iter", iter_cnt, idx);
        if (cyc == 0) chk("first_valid", out_valid, 1);
        if (out_valid) begin
          chk("value", out_val, exp_q[idx]);
          if (gap_on) chk("gap_len", gap, dly);
          gap_on = 0;
        end else if (gap_on) begin
          gap++;
        end else begin
          chk("valid_drop", out_valid, 1);
        end

        if (abort_idx >= 0 && idx == abort_idx && gap_on && !out_valid) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          chk("abort_iter", iter_cnt, idx);
          repeat (3) begin
            @(negedge clk);
            chk("abort_nodone", done, 0);
            chk("abort_novalid", out_valid, 0);
          end
          last_iter = idx;
          ok_end = 1;
        end else begin
          if (out_valid && exp_q[idx] == stall_val && stalls < stall_len) begin
            out_ready = 1'b0;
            stalls++;
          end else begin
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (out_valid && out_ready) begin
            idx++;
            if (idx == len) fin_next = 1;
            else begin
              gap_on = 1;
              gap = 0;
            end
          end
        end
      end
      if (!ok_end && poke && cyc == 2) begin
        start = 1'b1;
        scramble_cfg();
      end
    end
    start = 1'b0;
    if (!ok_end) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_val", out_val, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_iter", iter_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_sweep(1'b0, 3, 0, 0, 0, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b1, 0, 3, 10, 3, 2, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b1, 0, 5, 7, 1, 0, 1'b0, 6, 4, -1, 1'b0);
    run_sweep(1'b1, 0, 3, 9, 0, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b1, 0, 9, 4, 1, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b0, 0, 0, 0, 0, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b0, 9, 0, 0, 0, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b1, 0, 250, 255, 4, 0, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b1, 0, 255, 255, 1, 1, 1'b0, -1, 0, -1, 1'b0);
    run_sweep(1'b0, 3, 0, 0, 0, 2, 1'b0, -1, 0, 3, 1'b0);
    run_sweep(1'b0, 3, 0, 0, 0, 0, 1'b1, -1, 0, -1, 1'b0);

    // start and abort together in IDLE: no sweep.
    cfg_mode = 1'b1; cfg_start = 8'd1; cfg_stop = 8'd4; cfg_step = 8'd1;
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_valid", out_valid, 0);
    chk("sa_err", err, 0);
    chk("sa_iter", iter_cnt, last_iter);

    // Async reset mid-DRIVE with the consumer stalled.
    cfg_mode = 1'b1; cfg_start = 8'd10; cfg_stop = 8'd20; cfg_step = 8'd1;
    cfg_delay = '0; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_val", out_val, 0);
    chk("arst_busy", busy, 0);
    chk("arst_iter", iter_cnt, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    last_iter = 0;
    @(negedge clk);

    // Randomized sweeps, with random stalls and ignored mid-sweep starts.
    for (int k = 0; k < 40; k++) begin
      bit m;
      int wd, a, b, st, dly, tmp;
      m  = 1'($urandom_range(0, 1));
      wd = $urandom_range(0, 9);
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      if (m && a > b && $urandom_range(0, 3) != 0) begin
        tmp = a; a = b; b = tmp;
      end
      st  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 2) : $urandom_range(1, 60);
      dly = $urandom_range(0, 3);
      run_sweep(m, wd, a, b, st, dly, 1'b1, -1, 0, -1, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1);
  end

endmodule

// File: doc/sweep_seq_ctrl.md
Name: sweep_seq_ctrl

Overview:
- Synthesizable sweep sequencer. Emits a value sequence on a valid/ready stream, with a programmable idle gap between values.
- Two modes:
  - Full-range: 0 .. 2^N-1, step 1.
  - Custom-range: start .. stop inclusive, by step.
- Sits between a bench/host config interface and any DUT input port that needs exhaustive or ranged stimulus, on-chip or in emulation.
- Provides start/busy/done sequencing, abort, and config-error reporting.

Parameters:
- W, 32: value width in bits; also the maximum full-range width.
- DLY_W, 16: width of the inter-value delay counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; latches cfg_* when IDLE, ignored otherwise
- abort  in  1  terminate the sweep; return to IDLE next cycle
- cfg_mode  in  1  0 = full-range, 1 = custom-range
- cfg_width  in  $clog2(W+1)  full-range bit count N, legal 1..W
- cfg_start  in  W  first value, custom mode
- cfg_stop  in  W  last value (inclusive), custom mode
- cfg_step  in  W  increment, custom mode, must be nonzero
- cfg_delay  in  DLY_W  idle cycles between an accepted value and the next out_valid
- out_val  out  W  current value
- out_valid  out  1  out_val valid
- out_ready  in  1  consumer accepts
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final value is accepted
- err  out  1  one-cycle pulse on an illegal config at start
- iter_cnt  out  W+1  values accepted in the current/last sweep

Behaviour:
- Reset (asynchronous, active-high): state IDLE; out_val=0, out_valid=0, busy=0, done=0, err=0, iter_cnt=0.
- Unsigned arithmetic throughout.
- Config resolution on start in IDLE:
  - Full mode: start=0, stop=2^N-1, step=1.
  - Custom mode: cfg_* latched as-is.
- Illegal config:
  - Conditions: full mode with N=0 or N>W; custom mode with step=0 or start>stop.
  - Response: err=1 for the next cycle, state stays IDLE, iter_cnt unchanged, no output.
- Legal start: iter_cnt cleared. The next cycle enters DRIVE with out_valid=1 and out_val=start. Latency from start to first out_valid is 1 cycle.
- States: IDLE, DRIVE, WAIT, FIN.
  - IDLE: wait for start.
  - DRIVE: out_valid=1. out_val and out_valid are held stable until out_ready.
  - On handshake (out_valid & out_ready): iter_cnt++. next = cur + step, computed in W+1 bits.
    - If cur == stop, or next > stop, or next[W]==1 (wrap): go to FIN.
    - Else if delay==0: stay in DRIVE with out_val=next on the following cycle. Back-to-back throughput is 1 value/cycle.
    - Else: go to WAIT, with out_valid=0 and the delay counter loaded with delay.
  - WAIT: counter decrements each cycle. When it reaches 1, the next state is DRIVE with out_val=next. Exactly cfg_delay idle cycles with out_valid=0.
  - FIN: done=1 for exactly one cycle, out_valid=0. Next state IDLE.
- The stop value is always emitted if reachable by step. A sweep ending short of stop (step overshoot) ends at the last value ≤ stop.
- W=32 full range with N=32 yields 2^32 values. iter_cnt is W+1 bits so it does not overflow.
- Abort has priority over everything:
  - Any state goes to IDLE next cycle; out_valid=0 next cycle; done is not pulsed.
  - A handshake coincident with abort still counts in iter_cnt.
  - Abort in IDLE has no effect.
  - start and abort in the same IDLE cycle: abort wins, and the sweep does not start.
- start while busy is ignored; the config is not re-latched.
- Reset mid-sweep: immediate return to reset values.
- cfg_* are sampled only on the accepted start cycle and may change afterwards.

Decomposition:
- tb_util_pkg additions:
  - typedef enum for states {IDLE, DRIVE, WAIT, FIN}.
  - typedef for mode (FULL_RANGE=0, CUSTOM_RANGE=1).
  - Function resolve_cfg(mode, width, start, stop, step) returning resolved start/stop/step plus an illegal flag.
- One sub-module, sweep_delay_cnt: loadable down-counter, DLY_W wide, with a load/expire interface, instanced once.

Test Plan:
- Full mode, N=3, delay=0, out_ready=1:
  - out_val = 0,1,...,7 on 8 consecutive cycles, starting 1 cycle after start.
  - done pulses 1 cycle after the last handshake; iter_cnt=8.
- Custom start=3, stop=10, step=3, delay=2:
  - Values 3,6,9, each separated by exactly 2 out_valid=0 cycles.
  - 12 is not emitted; done pulses; iter_cnt=3.
- Backpressure, custom 5..7 step 1, out_ready low for 4 cycles on value 6:
  - out_val=6 is held stable with out_valid=1 throughout.
  - Sequence 5,6,7 completes; iter_cnt=3.
- Illegal configs:
  - step=0: err 1-cycle pulse, busy stays 0, no out_valid.
  - start=9, stop=4: same response.
  - Full mode with N=0: same response.
- Wrap, W=8, custom start=250, stop=255, step=4:
  - Values 250 then 254 (next 258 wraps), then done; iter_cnt=2.
  - start=stop=255, step=1: single value, then done.
- Abort and reset:
  - Abort during WAIT of a 0..7 sweep after value 2: out_valid stays 0, no done pulse, busy=0 next cycle, iter_cnt=3.
  - A new start then restarts from 0.
  - Async rst mid-DRIVE clears all outputs without a clock edge.
